display_mux: RTL and testbench

DISPLAY_MUX -- requirements
Module: display_mux

---
 rtl/display_pkg.sv | 29 ++
 rtl/seg7_decoder.sv | 26 ++
 rtl/display_mux.sv | 106 ++++++++++
 tb/tb_display_mux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the four-digit chess-clock display: segment codes and digit slot indices.
package display_pkg;

    // Active-low segment patterns, bit6..0 = g..a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDX_SU = 2'd0,
        IDX_ST = 2'd1,
        IDX_MU = 2'd2,
        IDX_MT = 2'd3
    } digit_idx_t;

    function automatic logic [3:0] anode_for(input digit_idx_t i);
        return ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed four-digit MM:SS display driver with frame-consistent snapshot and blinking colon.
module display_mux
    import display_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_HALF = 125
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic [3:0] MIN_TENS,
    input  logic [3:0] MIN_UNITS,
    input  logic [3:0] SEC_TENS,
    input  logic [3:0] SEC_UNITS,
    input  logic       ACTIVE,
    input  logic       BLANK_LEAD,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int              PRE_W      = 20;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [7:0]      BLINK_LAST = 8'(BLINK_HALF - 1);

    logic [PRE_W-1:0] pre_p0;
    digit_idx_t       idx_p0;
    logic [15:0]      snap_p0;
    logic [7:0]       blink_cnt_p0;
    logic             phase_p0;
    logic             init_p0;

    logic       tick;
    logic       frame_end;
    logic [3:0] digit;
    logic [6:0] digit_seg;
    logic       blank;
    logic       colon_lit;

    assign tick      = CE && (pre_p0 == PRE_LAST);
    assign frame_end = tick && (idx_p0 == IDX_MT);

    // Stage p0: scan timing, frame snapshot and colon blink state
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pre_p0       <= '0;
            idx_p0       <= IDX_SU;
            snap_p0      <= '0;
            blink_cnt_p0 <= '0;
            phase_p0     <= 1'b0;
            init_p0      <= 1'b1;
        end else begin
            init_p0 <= 1'b0;
            if (CE) begin
                pre_p0 <= tick ? '0 : pre_p0 + 1'b1;
                if (tick)
                    idx_p0 <= digit_idx_t'(idx_p0 + 2'd1);
                if (frame_end)
                    snap_p0 <= {MIN_TENS, MIN_UNITS, SEC_TENS, SEC_UNITS};
                if (!ACTIVE) begin
                    blink_cnt_p0 <= '0;
                    phase_p0     <= 1'b0;
                end else if (frame_end) begin
                    if (blink_cnt_p0 == BLINK_LAST) begin
                        blink_cnt_p0 <= '0;
                        phase_p0     <= ~phase_p0;
                    end else begin
                        blink_cnt_p0 <= blink_cnt_p0 + 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        digit = snap_p0[3:0];
        case (idx_p0)
            IDX_SU: digit = snap_p0[3:0];
            IDX_ST: digit = snap_p0[7:4];
            IDX_MU: digit = snap_p0[11:8];
            IDX_MT: digit = snap_p0[15:12];
        endcase
    end

    assign blank     = (idx_p0 == IDX_MT) && BLANK_LEAD && (snap_p0[15:12] == 4'd0);
    assign colon_lit = !ACTIVE || !phase_p0;

    seg7_decoder u_dec (
        .bcd (digit),
        .seg (digit_seg)
    );

    // Stage p1: registered drive; the first edge after reset always loads index 0
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            AN  <= 4'hF;
            SEG <= SEG_BLANK;
            DP  <= 1'b1;
        end else if (CE || init_p0) begin
            AN  <= blank ? 4'hF : anode_for(idx_p0);
            SEG <= blank ? SEG_BLANK : digit_seg;
            DP  <= !((idx_p0 == IDX_MU) && colon_lit);
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux (SCAN_DIV=4, BLINK_HALF=2) with a per-cycle expectation queue.
module tb_display_mux;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       CE;
    logic [3:0] MIN_TENS, MIN_UNITS, SEC_TENS, SEC_UNITS;
    logic       ACTIVE, BLANK_LEAD;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t        q[$];
    exp_t        last_exp;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] cur_snap;

    display_mux #(.SCAN_DIV(4), .BLINK_HALF(2)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .CE         (CE),
        .MIN_TENS   (MIN_TENS),
        .MIN_UNITS  (MIN_UNITS),
        .SEC_TENS   (SEC_TENS),
        .SEC_UNITS  (SEC_UNITS),
        .ACTIVE     (ACTIVE),
        .BLANK_LEAD (BLANK_LEAD),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        vectors++;
        assert ({AN, SEG, DP} === {ea, es, ed}) else begin
            miscompares++;
            $error("FAIL %s: got AN=%b SEG=%h DP=%b, expected AN=%b SEG=%h DP=%b",
                   tag, AN, SEG, DP, ea, es, ed);
        end
    endtask

    task automatic push_entry(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
        exp_t e;
        e.tag = tag; e.an = an; e.seg = seg; e.dp = dp;
        q.push_back(e);
    endtask

    // One frame = four slots of four cycles, index 0 (sec units) first
    task automatic push_frame(input string tag, input logic [15:0] snap, input logic blank_lead, input logic lit);
        for (int slot = 0; slot < 4; slot++) begin
            logic [3:0] d;
            logic [3:0] an;
            logic [6:0] sg;
            logic       dp;
            d  = snap[slot*4 +: 4];
            an = 4'hF;
            an[slot] = 1'b0;
            sg = seg_of(d);
            if (slot == 3 && blank_lead && d == 4'd0) begin
                an = 4'hF;
                sg = 7'h7F;
            end
            dp = (slot == 2 && lit) ? 1'b0 : 1'b1;
            for (int c = 0; c < 4; c++)
                push_entry($sformatf("%s_s%0d", tag, slot), an, sg, dp);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL queue_empty: got no expectation, required one per cycle");
            end else begin
                last_exp = q.pop_front();
                check(last_exp.tag, last_exp.an, last_exp.seg, last_exp.dp);
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic lit);
        push_frame(tag, cur_snap, BLANK_LEAD, lit);
        drain(16);
        cur_snap = {MIN_TENS, MIN_UNITS, SEC_TENS, SEC_UNITS};
    endtask

    task automatic set_time(input logic [15:0] t);
        {MIN_TENS, MIN_UNITS, SEC_TENS, SEC_UNITS} = t;
    endtask

    initial begin
        exp_t e;
        CLR = 1'b1; CE = 1'b0; ACTIVE = 1'b0; BLANK_LEAD = 1'b0;
        set_time(16'h0000);
        cur_snap = 16'h0000;

        // Reset state
        @(negedge CLK);
        check("reset", 4'hF, 7'h7F, 1'b1);

        // Release with CE=0: first edge still shows index 0, then holds
        CLR = 1'b0;
        set_time(16'h1234);
        push_entry("rel_ce0", 4'b1110, 7'h40, 1'b1);
        push_entry("rel_ce0_hold", 4'b1110, 7'h40, 1'b1);
        drain(2);

        // Zero snapshot frame, then 12:34
        CE = 1'b1;
        run_frame("f1_zero", 1'b1);
        MIN_TENS = 4'd0;
        run_frame("f2_1234", 1'b1);

        // Leading-zero blanking and dash for an illegal digit
        BLANK_LEAD = 1'b1;
        SEC_UNITS  = 4'hA;
        run_frame("blank_on", 1'b1);
        BLANK_LEAD = 1'b0;
        set_time(16'h5978);
        run_frame("blank_off_dash", 1'b1);

        // Colon blink: two frames lit, two dark
        ACTIVE = 1'b1;
        for (int k = 0; k < 10; k++)
            run_frame($sformatf("blink%0d", k), ((k / 2) % 2) == 0);
        ACTIVE = 1'b0;
        run_frame("steady", 1'b1);
        ACTIVE = 1'b1;
        for (int k = 0; k < 3; k++)
            run_frame($sformatf("reblink%0d", k), ((k / 2) % 2) == 0);
        ACTIVE = 1'b0;
        run_frame("colon_on", 1'b1);

        // Mid-frame input change and a 10-cycle CE stall inside slot 2
        push_frame("midchg", cur_snap, BLANK_LEAD, 1'b1);
        drain(8);
        set_time(16'h1357);
        drain(2);
        CE = 1'b0;
        e = last_exp;
        e.tag = "ce_hold";
        for (int i = 0; i < 10; i++)
            q.push_front(e);
        drain(10);
        CE = 1'b1;
        drain(6);
        cur_snap = {MIN_TENS, MIN_UNITS, SEC_TENS, SEC_UNITS};
        run_frame("after_chg", 1'b1);

        // Reset during index 2: asynchronous force, frame abandoned, zero snapshot
        push_frame("pre_clr", cur_snap, BLANK_LEAD, 1'b1);
        drain(9);
        #2 CLR = 1'b1;
        #1 check("clr_async", 4'hF, 7'h7F, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        check("clr_held", 4'hF, 7'h7F, 1'b1);
        q.delete();
        set_time(16'h2468);
        CLR = 1'b0;
        cur_snap = 16'h0000;
        run_frame("post_clr", 1'b1);
        run_frame("post_clr_snap", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
